// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the five-stage MIPS pipeline.
// Uses architectural delay slots (no D flush); flags bad fetches and counts fetch/stall cycles.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enPC,
  input  logic        enD,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_D,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        valid_D,
  output logic        ferr_D,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  // 33-bit end bound so a memory ending at 4 GiB does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_f;
  logic [31:0] npc;
  logic [31:0] br_off;
  logic        ferr_f;
  npc_sel_e    sel;

  assign im_addr = pc_f;
  assign pc8_D   = pc_D + 32'd8;
  assign sel     = npc_sel_e'(npc_sel);
  assign br_off  = {{14{instr_D[15]}}, instr_D[15:0], 2'b00};

  always_comb begin
    ferr_f = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || ({1'b0, pc_f} >= IM_END);
  end

  // Redirects only act on a real instruction in D; otherwise fetch falls through.
  always_comb begin
    npc = pc_f + 32'd4;
    if (valid_D) begin
      unique case (sel)
        NPC_BR:  if (br_taken) npc = pc_D + 32'd4 + br_off;
        NPC_J:   npc = {pc_D[31:28], instr_D[25:0], 2'b00};
        NPC_JR:  npc = rs_D;
        default: npc = pc_f + 32'd4;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f      <= PC_RESET;
      instr_D   <= '0;
      pc_D      <= '0;
      valid_D   <= 1'b0;
      ferr_D    <= 1'b0;
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (enPC) pc_f <= npc;
      else      stall_cnt <= stall_cnt + 32'd1;
      if (enD) begin
        instr_D <= ferr_f ? '0 : im_rdata;
        pc_D    <= pc_f;
        ferr_D  <= ferr_f;
        valid_D <= 1'b1;
        if (!ferr_f) fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline, directly upstream of the hazard stall unit: it holds PC_F, drives the instruction-memory address, latches the fetched word into the D stage and supplies `instr_D` for hazard and decode logic. It obeys the `enPC` and `enD` freeze enables produced by the stall unit. It computes the next PC from the D-stage control-flow decision, using architectural branch-delay slots, so there is no D flush. Misaligned and out-of-range fetches are flagged, and fetch/stall cycles are counted for debug.

## Interface
- `PC_RESET`, 32'h0000_3000, PC_F value after reset
- `IM_BASE`, 32'h0000_3000, byte address of instruction-memory word 0
- `IM_WORDS`, 4096, instruction-memory depth in words
- `clk` input 1: the only clock; all state updates on its rising edge
- `reset` input 1: asynchronous, active-low; clears all state immediately while low
- `enPC` input 1: 1 = PC_F may update; 0 = PC_F holds (stall)
- `enD` input 1: 1 = IF/ID register loads; 0 = IF/ID register holds
- `npc_sel` input 2: 0 sequential, 1 branch, 2 j/jal, 3 jr/jalr (decoded from `instr_D`)
- `br_taken` input 1: D-stage compare result for the branch in D
- `rs_D` input 32: forwarded GPR[rs] of the D instruction (jr target)
- `im_addr` output 32: equals PC_F
- `im_rdata` input 32: combinational instruction-memory read data for `im_addr`
- `instr_D` output 32: instruction in D
- `pc_D` output 32: PC of instruction in D
- `pc8_D` output 32: `pc_D` + 8 (link address)
- `valid_D` output 1: D holds a real fetched instruction
- `ferr_D` output 1: D instruction came from a bad fetch
- `fetch_cnt` output 32: count of good instructions loaded into D
- `stall_cnt` output 32: count of cycles with `enPC` = 0

## Operation
- Fetch check: `ferr_F` = (PC_F[1:0] != 0) or (PC_F < `IM_BASE`) or (PC_F >= `IM_BASE` + 4*`IM_WORDS`). If `ferr_F` is set, the word captured into D is 32'h0 (nop), not `im_rdata`.
- Next-PC selection:
  - If `valid_D`=1, `npc_sel`=1 and `br_taken`=1: `pc_D` + 4 + (sign-extended `instr_D[15:0]` << 2).
  - If `valid_D`=1 and `npc_sel`=2: {`pc_D[31:28]`, `instr_D[25:0]`, 2'b00}.
  - If `valid_D`=1 and `npc_sel`=3: `rs_D`, unmodified; misalignment is caught by the fetch check on the next cycle.
  - Otherwise: PC_F + 4.
  - All arithmetic is 32-bit modulo 2^32. PC_F = 32'hFFFF_FFFC + 4 wraps to 0, which is flagged by the fetch check.
- Delay slot: when a branch or jump is in D, the instruction in F (its delay slot) is still loaded into D normally. The redirect takes effect in the following fetch.
- Stall: when `enPC`=0, PC_F holds and any redirect request is ignored. The D instruction is held and re-evaluates its branch once the stall releases.
- IF/ID register: when `enD`=1 it loads {fetched word, PC_F, `ferr_F`} and sets `valid_D`=1. When `enD`=0, all D outputs hold.
- Counters:
  - `fetch_cnt` increments when `enD`=1 and `ferr_F`=0.
  - `stall_cnt` increments on each cycle with `enPC`=0.
  - Both wrap from 32'hFFFF_FFFF to 0.
- The `enPC`≠`enD` combination is not produced by the stall unit. Each enable acts independently on its own register; the bench need not cover it.

## Timing
- Reset values (asynchronous):
  - PC_F = `PC_RESET`.
  - `instr_D` = 0, `pc_D` = 0, `pc8_D` = 8.
  - `valid_D` = 0, `ferr_D` = 0.
  - `fetch_cnt` = 0, `stall_cnt` = 0.
- Reset asserted mid-operation clears state within the same cycle, with no clock edge required. The first edge after `reset` deasserts loads the word at `PC_RESET` into D.
- `im_addr` follows PC_F combinationally. Fetch to D takes 1 cycle.
- The redirect decision is combinational from D-stage inputs and is applied on the same rising edge that loads the delay slot into D. The target is fetched on the next cycle.
- A stall released at edge k resumes fetch at the held PC_F. No instruction is lost or duplicated.

## Test plan
- Reset, then 3 free-running cycles with `enPC`=`enD`=1: `im_addr` = 3000, 3004, 3008, 300C; `pc_D` = 3000 after edge 1; `pc8_D` = 3008; `fetch_cnt` = 3.
- Hold `enPC`=`enD`=0 for 2 cycles with PC_F=3008: `im_addr` and `instr_D` unchanged; `stall_cnt` = 2; fetch then resumes at 3008 with no skipped PC.
- beq at 3000 with imm=4 and `br_taken`=1: the delay slot at 3004 enters D, then `im_addr` = 3014. With `br_taken`=0: `im_addr` = 3008.
- j at 3010 with index=0x0C01: after the delay slot, `im_addr` = 3004. jr at 3020 with `rs_D`=3100: after the delay slot, `im_addr` = 3100.
- jr with `rs_D`=3002: the next D has `instr_D`=0 and `ferr_D`=1, and `fetch_cnt` does not increment.
- Pull `reset` low mid-cycle while PC_F=3040: `im_addr` = 3000 and `valid_D` = 0 immediately, before the next clock edge.
